id_to_ex_pipeline: RTL

- ID/EX pipeline register directly upstream of the EX-stage forwarding mux.
- Registers decoded operands and control from ID, and feeds the EX forwarding logic its read address and read data.
- Detects load-use hazards, inserts bubbles, and handles external stall and branch flush.
- Refreshes held operand data from WB write-back while stalled, so no retiring result is lost.

---
 rtl/id_to_ex_pipeline_pkg.sv | 45 ++++
 rtl/id_to_ex_pipeline_if.sv | 83 ++++++++
 rtl/id_to_ex_pipeline_operand_refresh.sv | 26 ++
 rtl/id_to_ex_pipeline.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/id_to_ex_pipeline_pkg.sv
// Shared types and widths for the ID/EX pipeline register.
// Control bundle is packed so a bubble is simply '0.
package id_to_ex_pipeline_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_NOP = 4'd0,
    ALU_ADD = 4'd1,
    ALU_SUB = 4'd2,
    ALU_AND = 4'd3,
    ALU_OR  = 4'd4,
    ALU_XOR = 4'd5,
    ALU_SLT = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src;
    logic    mem_read;
    logic    mem_write;
    logic    reg_write;
    logic    mem_to_reg;
  } ex_ctrl_t;

  typedef enum logic [1:0] {
    M_LOAD,
    M_HOLD,
    M_BUBBLE
  } mode_e;

  // r0 is hardwired, so a write to it never bypasses
  function automatic logic wb_hit(
    input logic              we,
    input logic [ADDR_W-1:0] wa,
    input logic [ADDR_W-1:0] ra
  );
    return we & (wa != '0) & (wa == ra);
  endfunction

endpackage

// File: rtl/id_to_ex_pipeline_if.sv
// ID-side inputs, WB bypass and EX-side outputs of the ID/EX register.
// master drives ID/WB/control, slave is the pipeline register itself.
interface id_to_ex_pipeline_if #(
  parameter int CNT_W = 16
);
  import id_to_ex_pipeline_pkg::*;

  logic                stall_i;
  logic                flush_i;
  logic                id_valid_i;
  logic [ADDR_W-1:0]   id_rs_addr_i;
  logic [ADDR_W-1:0]   id_rt_addr_i;
  logic [DATA_W-1:0]   id_rs_data_i;
  logic [DATA_W-1:0]   id_rt_data_i;
  logic                id_uses_rs_i;
  logic                id_uses_rt_i;
  logic [ADDR_W-1:0]   id_dst_addr_i;
  logic [DATA_W-1:0]   id_imm_i;
  logic [ALU_OP_W-1:0] id_alu_op_i;
  logic                id_alu_src_i;
  logic                id_mem_read_i;
  logic                id_mem_write_i;
  logic                id_reg_write_i;
  logic                id_mem_to_reg_i;
  logic                wb_reg_write_i;
  logic [ADDR_W-1:0]   wb_addr_i;
  logic [DATA_W-1:0]   wb_data_i;

  logic                ex_valid_o;
  logic [ADDR_W-1:0]   ex_rs_addr_o;
  logic [ADDR_W-1:0]   ex_rt_addr_o;
  logic [DATA_W-1:0]   ex_rs_data_o;
  logic [DATA_W-1:0]   ex_rt_data_o;
  logic [ADDR_W-1:0]   ex_dst_addr_o;
  logic [DATA_W-1:0]   ex_imm_o;
  logic [ALU_OP_W-1:0] ex_alu_op_o;
  logic                ex_alu_src_o;
  logic                ex_mem_read_o;
  logic                ex_mem_write_o;
  logic                ex_reg_write_o;
  logic                ex_mem_to_reg_o;
  logic                load_use_stall_o;
  logic [CNT_W-1:0]    bubble_count_o;

  modport master (
    output stall_i, flush_i, id_valid_i,
    output id_rs_addr_i, id_rt_addr_i,
    output id_rs_data_i, id_rt_data_i,
    output id_uses_rs_i, id_uses_rt_i,
    output id_dst_addr_i, id_imm_i, id_alu_op_i,
    output id_alu_src_i, id_mem_read_i,
    output id_mem_write_i, id_reg_write_i,
    output id_mem_to_reg_i,
    output wb_reg_write_i, wb_addr_i, wb_data_i,
    input  ex_valid_o, ex_rs_addr_o, ex_rt_addr_o,
    input  ex_rs_data_o, ex_rt_data_o,
    input  ex_dst_addr_o, ex_imm_o, ex_alu_op_o,
    input  ex_alu_src_o, ex_mem_read_o,
    input  ex_mem_write_o, ex_reg_write_o,
    input  ex_mem_to_reg_o,
    input  load_use_stall_o, bubble_count_o
  );

  modport slave (
    input  stall_i, flush_i, id_valid_i,
    input  id_rs_addr_i, id_rt_addr_i,
    input  id_rs_data_i, id_rt_data_i,
    input  id_uses_rs_i, id_uses_rt_i,
    input  id_dst_addr_i, id_imm_i, id_alu_op_i,
    input  id_alu_src_i, id_mem_read_i,
    input  id_mem_write_i, id_reg_write_i,
    input  id_mem_to_reg_i,
    input  wb_reg_write_i, wb_addr_i, wb_data_i,
    output ex_valid_o, ex_rs_addr_o, ex_rt_addr_o,
    output ex_rs_data_o, ex_rt_data_o,
    output ex_dst_addr_o, ex_imm_o, ex_alu_op_o,
    output ex_alu_src_o, ex_mem_read_o,
    output ex_mem_write_o, ex_reg_write_o,
    output ex_mem_to_reg_o,
    output load_use_stall_o, bubble_count_o
  );

endinterface

// File: rtl/id_to_ex_pipeline_operand_refresh.sv
// Operand source select with write-first WB bypass.
// Held operand tracks its own address; fresh operand tracks ID's.
module id_ex_operand_refresh
  import id_to_ex_pipeline_pkg::*;
(
  input  logic              hold_i,
  input  logic [ADDR_W-1:0] id_addr_i,
  input  logic [DATA_W-1:0] id_data_i,
  input  logic [ADDR_W-1:0] ex_addr_i,
  input  logic [DATA_W-1:0] ex_data_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic [DATA_W-1:0] data_o
);

  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  assign sel_addr = hold_i ? ex_addr_i : id_addr_i;
  assign sel_data = hold_i ? ex_data_i : id_data_i;

  assign data_o = wb_hit(wb_we_i, wb_addr_i, sel_addr)
                ? wb_data_i : sel_data;

endmodule

// File: rtl/id_to_ex_pipeline.sv
// ID/EX pipeline register with load-use bubble insertion,
// stall hold, branch flush and WB operand refresh.
module id_to_ex_pipeline
  import id_to_ex_pipeline_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic          clk_i,
  input logic          rst_n_i,
  id_to_ex_pipeline_if.slave bus
);

  logic              valid_q, valid_d;
  ex_ctrl_t          ctrl_q, ctrl_d, id_ctrl;
  logic [ADDR_W-1:0] rs_addr_q, rs_addr_d;
  logic [ADDR_W-1:0] rt_addr_q, rt_addr_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rs_sel, rt_sel;
  logic              rs_dep, rt_dep;
  logic              hazard, lu_stall;
  logic              id_v;
  mode_e             mode;

  assign id_v   = bus.id_valid_i;
  assign rs_dep = bus.id_uses_rs_i
                & (bus.id_rs_addr_i == dst_q);
  assign rt_dep = bus.id_uses_rt_i
                & (bus.id_rt_addr_i == dst_q);

  assign hazard = valid_q & ctrl_q.mem_read
                & ctrl_q.reg_write & id_v
                & (rs_dep | rt_dep);

  assign lu_stall = hazard & ~bus.flush_i
                  & ~bus.stall_i;

  always_comb begin
    mode = M_LOAD;
    if (bus.stall_i) begin
      mode = M_HOLD;
    end else if (bus.flush_i || hazard) begin
      mode = M_BUBBLE;
    end
  end

  always_comb begin
    id_ctrl            = '0;
    id_ctrl.alu_op     = alu_op_e'(bus.id_alu_op_i
                       & {ALU_OP_W{id_v}});
    id_ctrl.alu_src    = bus.id_alu_src_i & id_v;
    id_ctrl.mem_read   = bus.id_mem_read_i & id_v;
    id_ctrl.mem_write  = bus.id_mem_write_i & id_v;
    id_ctrl.mem_to_reg = bus.id_mem_to_reg_i & id_v;
    // r0 must never look like a forwarding source
    id_ctrl.reg_write  = bus.id_reg_write_i & id_v
                       & (bus.id_dst_addr_i != '0);
  end

  id_ex_operand_refresh u_rs (
    .hold_i    (bus.stall_i),
    .id_addr_i (bus.id_rs_addr_i),
    .id_data_i (bus.id_rs_data_i),
    .ex_addr_i (rs_addr_q),
    .ex_data_i (rs_data_q),
    .wb_we_i   (bus.wb_reg_write_i),
    .wb_addr_i (bus.wb_addr_i),
    .wb_data_i (bus.wb_data_i),
    .data_o    (rs_sel)
  );

  id_ex_operand_refresh u_rt (
    .hold_i    (bus.stall_i),
    .id_addr_i (bus.id_rt_addr_i),
    .id_data_i (bus.id_rt_data_i),
    .ex_addr_i (rt_addr_q),
    .ex_data_i (rt_data_q),
    .wb_we_i   (bus.wb_reg_write_i),
    .wb_addr_i (bus.wb_addr_i),
    .wb_data_i (bus.wb_data_i),
    .data_o    (rt_sel)
  );

  always_comb begin
    valid_d   = valid_q;
    ctrl_d    = ctrl_q;
    rs_addr_d = rs_addr_q;
    rt_addr_d = rt_addr_q;
    dst_d     = dst_q;
    imm_d     = imm_q;
    rs_data_d = rs_sel;
    rt_data_d = rt_sel;
    cnt_d     = cnt_q;
    unique case (mode)
      M_HOLD: begin
      end
      M_BUBBLE: begin
        valid_d   = 1'b0;
        ctrl_d    = '0;
        rs_addr_d = '0;
        rt_addr_d = '0;
        dst_d     = '0;
        imm_d     = '0;
        rs_data_d = '0;
        rt_data_d = '0;
        if (lu_stall && !(&cnt_q)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        valid_d   = id_v;
        ctrl_d    = id_ctrl;
        rs_addr_d = bus.id_rs_addr_i;
        rt_addr_d = bus.id_rt_addr_i;
        dst_d     = bus.id_dst_addr_i;
        imm_d     = bus.id_imm_i;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      dst_q     <= '0;
      imm_q     <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      rs_addr_q <= rs_addr_d;
      rt_addr_q <= rt_addr_d;
      dst_q     <= dst_d;
      imm_q     <= imm_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.ex_valid_o       = valid_q;
  assign bus.ex_rs_addr_o     = rs_addr_q;
  assign bus.ex_rt_addr_o     = rt_addr_q;
  assign bus.ex_rs_data_o     = rs_data_q;
  assign bus.ex_rt_data_o     = rt_data_q;
  assign bus.ex_dst_addr_o    = dst_q;
  assign bus.ex_imm_o         = imm_q;
  assign bus.ex_alu_op_o      = ctrl_q.alu_op;
  assign bus.ex_alu_src_o     = ctrl_q.alu_src;
  assign bus.ex_mem_read_o    = ctrl_q.mem_read;
  assign bus.ex_mem_write_o   = ctrl_q.mem_write;
  assign bus.ex_reg_write_o   = ctrl_q.reg_write;
  assign bus.ex_mem_to_reg_o  = ctrl_q.mem_to_reg;
  assign bus.load_use_stall_o = lu_stall;
  assign bus.bubble_count_o   = cnt_q;

endmodule
